mem16_bridge: RTL and testbench
===============================

# mem16_bridge

Initiator-side bridge that turns 16-bit word and 8-bit byte requests from the CPU/bus side into sequences of single-byte accesses on the team's 32 KiB × 8 synchronous-write / asynchronous-read RAM port. It sits between the core's memory request channel and the byte RAM. It owns address sequencing, byte ordering, read-data assembly and the one-transaction-at-a-time handshake.

## Interface
- `ADDR_W`, default 15: RAM byte-address width (RAM depth = 2^ADDR_W bytes).
- `BIG_ENDIAN`, default 1: if 1, the high byte of a word lives at `A` and the low byte at `A+1`; if 0, the reverse.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept a request this cycle.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_byte` in 1: 1 = byte access, 0 = word access.
- `req_addr` in ADDR_W: byte address. Unaligned word accesses are allowed.
- `req_wdata` in 16: write data. For byte writes, `[7:0]` is used.
- `rsp_valid` out 1: one-cycle completion pulse, issued for both reads and writes.
- `rsp_rdata` out 16: read data, valid with `rsp_valid`. Byte reads return `{8'h00, byte}`. Writes return 0.
- `mem_en` out 1: RAM enable.
- `mem_wr` out 1: RAM write strobe.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out 8: RAM write data.
- `mem_rdata` in 8: RAM read data. It is combinational from `mem_addr` and valid in the same cycle.

## Operation
- States: IDLE, ACC0, ACC1, DONE.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch `wr`, `byte`, `addr`, `wdata` and go to ACC0.
- ACC0:
  - Drive `mem_en=1`, `mem_wr=wr`, `mem_addr=A`.
  - For a word, `mem_wdata` is the high byte if `BIG_ENDIAN`, else the low byte. For a byte access it is `wdata[7:0]`.
  - On a read, capture `mem_rdata` into the corresponding half of the read register.
  - Next state: ACC1 for a word, DONE for a byte.
- ACC1 (word accesses only):
  - Same as ACC0, but at `mem_addr=A+1` with the other byte.
  - `A+1` is computed modulo 2^ADDR_W, so 0x7FFF wraps to 0x0000.
  - Next state: DONE.
- DONE:
  - `rsp_valid=1` and `rsp_rdata` = the assembled word.
  - `req_ready=0`.
  - Next state: IDLE.
- `mem_en=0` and `mem_wr=0` in IDLE and DONE. `mem_addr` and `mem_wdata` are don't-care when `mem_en=0`, but are held stable (no glitch toggling) to ease waveform checking.
- Only one transaction is in flight at a time. There is no response backpressure: the consumer must take `rsp_valid` when it pulses.
- Request inputs are ignored outside IDLE.
- Read register halves that are not written during a transaction read as 0. The read register is cleared on accept.

## Timing
- Reset values:
  - state = IDLE.
  - `req_ready=0` while `reset` is high, then 1 on the first cycle after `reset` falls.
  - `rsp_valid=0`, `rsp_rdata=0`, `mem_en=0`, `mem_wr=0`, `mem_addr=0`, `mem_wdata=0`.
- Cycle counts, with acceptance at cycle 0:
  - Word: RAM accesses in cycles 1 and 2, `rsp_valid` in cycle 3, next accept possible in cycle 4. Throughput is 4 cycles per word.
  - Byte: RAM access in cycle 1, `rsp_valid` in cycle 2. Throughput is 3 cycles per byte.
- Writes commit at the rising edge that ends the ACC cycle.
- `rsp_rdata` holds its value after `rsp_valid` falls, until the next accept clears it.
- Reset mid-operation:
  - Next state is IDLE with no response.
  - A byte already written in ACC0 stays written (the transaction is not atomic).
  - A request presented in the reset cycle is not accepted.
- `req_valid` asserted in DONE is not accepted until the following IDLE cycle.

## Structure
- Shared package/header holds:
  - State encodings (2 bits: IDLE=0, ACC0=1, ACC1=2, DONE=3).
  - The `BIG_ENDIAN` default.
  - Response-data zero constant.
- Single flat module: one FSM, a latched request register, and a 16-bit read register.
- No sub-module is natural. The RAM itself is instantiated only in the bench/top level.

## Test plan
- Word write then read, `BIG_ENDIAN=1`:
  - Write 0x1234 to 0x0100, then read 0x0100.
  - RAM holds [0x0100]=0x12 and [0x0101]=0x34.
  - Read gives `rsp_rdata=0x1234` in cycle 3 after accept.
- Unaligned and wrapping word, `BIG_ENDIAN=0`:
  - Write 0xBEEF to 0x7FFF.
  - RAM holds [0x7FFF]=0xEF and [0x0000]=0xBE.
  - Readback gives 0xBEEF.
- Byte access:
  - Byte write 0xA5 to 0x0042; a word at 0x0042 was previously 0x1122.
  - Byte read of 0x0042 returns 0x00A5.
  - Word read of 0x0042 returns 0xA522.
  - Byte transactions complete in 2 cycles from accept to `rsp_valid`.
- Back-to-back handshake:
  - Hold `req_valid=1` continuously with 3 word reads.
  - Accepts occur at cycles 0, 4 and 8 exactly.
  - `req_ready` is low in cycles 1–3.
  - Exactly 3 `rsp_valid` pulses.
- Reset mid-word-write:
  - Assert `reset` in the ACC1 cycle of a 0xCAFE write to 0x0010.
  - [0x0010]=0xCA is written; [0x0011] is unchanged.
  - No `rsp_valid`.
  - All outputs take their reset values.
  - A new request is accepted on the first cycle after reset.
- Reset-cycle request:
  - `req_valid=1` during reset produces no RAM access and no response.

Source files
------------

// File: rtl/mem16_bridge_pkg.sv
// Shared definitions for the 16-bit-to-byte RAM bridge: state encodings,
// endianness default and response constants.
package mem16_bridge_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam bit BIG_ENDIAN_DEFAULT = 1'b1;

  localparam logic [15:0] RSP_ZERO = 16'h0000;

  // Select the high (hi=1) or low byte lane of a 16-bit word.
  function automatic logic [7:0] lane_byte(input logic [15:0] w, input logic hi);
    return hi ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/mem16_bridge_if.sv
// Request/response channel plus byte-RAM port of the bridge; slave is the
// bridge's own view, master the core/RAM side.
interface mem16_bridge_if #(
  parameter int unsigned ADDR_W = 15
);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [15:0]       req_wdata;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req_valid, req_wr, req_byte, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_wr, req_byte, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem16_bridge.sv
// Splits 16-bit word / 8-bit byte requests into single-byte accesses on an
// async-read, sync-write byte RAM; one transaction in flight at a time.
module mem16_bridge
  import mem16_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter bit          BIG_ENDIAN = BIG_ENDIAN_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  mem16_bridge_if.slave bus
);

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic              wr_q;
  logic              byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [15:0]       rdata_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [7:0]        mwdata_q;
  logic              accept;
  logic              in_acc;
  logic              hi_lane;

  assign accept = bus.req_valid && bus.req_ready;
  assign in_acc = (state_q == ST_ACC0) || (state_q == ST_ACC1);

  // Strobes are masked by reset so a reset landing in an ACC cycle
  // cannot commit a write at the edge that ends it.
  assign bus.req_ready = (state_q == ST_IDLE) && !reset;
  assign bus.mem_en    = in_acc && !reset;
  assign bus.mem_wr    = in_acc && wr_q && !reset;
  assign bus.rsp_valid = (state_q == ST_DONE) && !reset;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = mwdata_q;

  // The first access carries the high byte when big-endian, so the high
  // half is targeted in ACC0 iff BIG_ENDIAN; byte accesses use the low half.
  assign hi_lane = !byte_q && ((state_q == ST_ACC0) == BIG_ENDIAN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_ACC0;
      ST_ACC0: state_d = byte_q ? ST_DONE : ST_ACC1;
      ST_ACC1: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= RSP_ZERO;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q     <= bus.req_wr;
        byte_q   <= bus.req_byte;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        rdata_q  <= RSP_ZERO;
        maddr_q  <= bus.req_addr;
        mwdata_q <= bus.req_byte ? bus.req_wdata[7:0]
                                 : lane_byte(bus.req_wdata, BIG_ENDIAN);
      end
      // Address/data registers only move when entering an access cycle,
      // which keeps them stable through IDLE and DONE.
      if (state_q == ST_ACC0 && !byte_q) begin
        maddr_q  <= addr_q + ADDR_W'(1);
        mwdata_q <= lane_byte(wdata_q, !BIG_ENDIAN);
      end
      if (in_acc && !wr_q) begin
        if (hi_lane) rdata_q[15:8] <= bus.mem_rdata;
        else         rdata_q[7:0]  <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem16_bridge.sv
// Directed bench: big- and little-endian bridges driven in lockstep, each
// with its own byte RAM model, checked against hand-computed values.
module tb_mem16_bridge;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_wr;
  logic        req_byte;
  logic [14:0] req_addr;
  logic [15:0] req_wdata;

  logic [7:0] ram_be [0:32767];
  logic [7:0] ram_le [0:32767];

  int checks = 0;
  int errors = 0;

  mem16_bridge_if #(.ADDR_W(15)) if_be ();
  mem16_bridge_if #(.ADDR_W(15)) if_le ();

  assign if_be.req_valid = req_valid;
  assign if_be.req_wr    = req_wr;
  assign if_be.req_byte  = req_byte;
  assign if_be.req_addr  = req_addr;
  assign if_be.req_wdata = req_wdata;
  assign if_le.req_valid = req_valid;
  assign if_le.req_wr    = req_wr;
  assign if_le.req_byte  = req_byte;
  assign if_le.req_addr  = req_addr;
  assign if_le.req_wdata = req_wdata;

  assign if_be.mem_rdata = ram_be[if_be.mem_addr];
  assign if_le.mem_rdata = ram_le[if_le.mem_addr];

  always @(posedge clk) begin
    if (if_be.mem_en && if_be.mem_wr) ram_be[if_be.mem_addr] <= if_be.mem_wdata;
    if (if_le.mem_en && if_le.mem_wr) ram_le[if_le.mem_addr] <= if_le.mem_wdata;
  end

  mem16_bridge #(.ADDR_W(15), .BIG_ENDIAN(1'b1)) dut_be (
    .clk   (clk),
    .reset (reset),
    .bus   (if_be)
  );

  mem16_bridge #(.ADDR_W(15), .BIG_ENDIAN(1'b0)) dut_le (
    .clk   (clk),
    .reset (reset),
    .bus   (if_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge with the bridges idle; returns once the
  // response has been sampled and the next IDLE cycle has begun.
  task automatic txn(input string tag, input logic wr, input logic byt,
                     input logic [14:0] a, input logic [15:0] wd,
                     output logic [15:0] rd_be, output logic [15:0] rd_le);
    int n;
    int lat;
    logic [14:0] a1;
    a1 = a + 15'd1;
    req_valid = 1'b1;
    req_wr    = wr;
    req_byte  = byt;
    req_addr  = a;
    req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!if_be.req_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "/wait"}, n, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        check({tag, "/en0"},    32'(if_be.mem_en), 32'd1);
        check({tag, "/wr0"},    32'(if_be.mem_wr), 32'(wr));
        check({tag, "/addr0"},  32'(if_be.mem_addr), 32'(a));
        check({tag, "/addr0l"}, 32'(if_le.mem_addr), 32'(a));
        check({tag, "/wd0"},    32'(if_be.mem_wdata), byt ? 32'(wd[7:0]) : 32'(wd[15:8]));
        check({tag, "/wd0l"},   32'(if_le.mem_wdata), 32'(wd[7:0]));
      end
      if (lat == 2 && !byt) begin
        check({tag, "/en1"},    32'(if_be.mem_en), 32'd1);
        check({tag, "/addr1"},  32'(if_be.mem_addr), 32'(a1));
        check({tag, "/addr1l"}, 32'(if_le.mem_addr), 32'(a1));
        check({tag, "/wd1"},    32'(if_be.mem_wdata), 32'(wd[7:0]));
        check({tag, "/wd1l"},   32'(if_le.mem_wdata), 32'(wd[15:8]));
      end
    end while (!if_be.rsp_valid && lat < 8);
    check({tag, "/lat"}, lat, byt ? 32'd2 : 32'd3);
    check({tag, "/le_rsp"}, 32'(if_le.rsp_valid), 32'd1);
    rd_be = if_be.rsp_rdata;
    rd_le = if_le.rsp_rdata;
    @(posedge clk);
    #1;
    check({tag, "/rsp_drop"}, 32'(if_be.rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] rb;
    logic [15:0] rl;
    int acc[$];
    int nrsp;

    reset = 1'b1;
    req_valid = 1'b0;
    req_wr = 1'b0;
    req_byte = 1'b0;
    req_addr = '0;
    req_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  32'(if_be.req_ready), 32'd0);
    check("rst_rsp",    32'(if_be.rsp_valid), 32'd0);
    check("rst_rdata",  32'(if_be.rsp_rdata), 32'd0);
    check("rst_en",     32'(if_be.mem_en), 32'd0);
    check("rst_wr",     32'(if_be.mem_wr), 32'd0);
    check("rst_addr",   32'(if_be.mem_addr), 32'd0);
    check("rst_wdata",  32'(if_be.mem_wdata), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(if_be.req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Word write/read at 0x0100
    txn("w1234", 1'b1, 1'b0, 15'h0100, 16'h1234, rb, rl);
    check("w1234_rdata0", 32'(rb), 32'h0);
    check("ram_be_100", 32'(ram_be[15'h0100]), 32'h12);
    check("ram_be_101", 32'(ram_be[15'h0101]), 32'h34);
    check("ram_le_100", 32'(ram_le[15'h0100]), 32'h34);
    check("ram_le_101", 32'(ram_le[15'h0101]), 32'h12);
    txn("r0100", 1'b0, 1'b0, 15'h0100, 16'h0000, rb, rl);
    check("r0100_be", 32'(rb), 32'h1234);
    check("r0100_le", 32'(rl), 32'h1234);
    check("rdata_hold", 32'(if_be.rsp_rdata), 32'h1234);

    // Unaligned word straddling the top of the address space
    txn("wbeef", 1'b1, 1'b0, 15'h7FFF, 16'hBEEF, rb, rl);
    check("ram_le_7fff", 32'(ram_le[15'h7FFF]), 32'hEF);
    check("ram_le_0000", 32'(ram_le[15'h0000]), 32'hBE);
    check("ram_be_7fff", 32'(ram_be[15'h7FFF]), 32'hBE);
    check("ram_be_0000", 32'(ram_be[15'h0000]), 32'hEF);
    txn("rbeef", 1'b0, 1'b0, 15'h7FFF, 16'h0000, rb, rl);
    check("rbeef_be", 32'(rb), 32'hBEEF);
    check("rbeef_le", 32'(rl), 32'hBEEF);

    // Byte write into an existing word
    txn("w1122", 1'b1, 1'b0, 15'h0042, 16'h1122, rb, rl);
    txn("wbA5",  1'b1, 1'b1, 15'h0042, 16'h33A5, rb, rl);
    check("wbA5_rdata0", 32'(rb), 32'h0);
    txn("rbA5",  1'b0, 1'b1, 15'h0042, 16'h0000, rb, rl);
    check("rbA5_be", 32'(rb), 32'h00A5);
    check("rbA5_le", 32'(rl), 32'h00A5);
    txn("rw42",  1'b0, 1'b0, 15'h0042, 16'h0000, rb, rl);
    check("rw42_be", 32'(rb), 32'hA522);
    check("rw42_le", 32'(rl), 32'h11A5);

    // Back-to-back word reads with req_valid held high
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_byte = 1'b0;
    req_addr = 15'h0100;
    req_wdata = 16'h0000;
    nrsp = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (cyc < 12) check("b2b_ready", 32'(if_be.req_ready), (cyc % 4 == 0) ? 32'd1 : 32'd0);
      if (if_be.req_ready && req_valid) acc.push_back(cyc);
      if (if_be.rsp_valid) begin
        nrsp++;
        check("b2b_rdata", 32'(if_be.rsp_rdata), 32'h1234);
      end
      @(posedge clk);
      #1;
      if (acc.size() == 3) req_valid = 1'b0;
    end
    check("b2b_accepts", acc.size(), 3);
    for (int i = 0; i < acc.size() && i < 3; i++) check("b2b_acc_cycle", acc[i], 4 * i);
    check("b2b_rsp_count", nrsp, 3);

    // Known contents around the reset-interrupted write
    txn("w5a", 1'b1, 1'b1, 15'h0011, 16'h005A, rb, rl);
    txn("w00", 1'b1, 1'b1, 15'h0010, 16'h0000, rb, rl);
    txn("w20", 1'b1, 1'b1, 15'h0020, 16'h0000, rb, rl);

    // Reset during ACC1 of a word write, with a request presented under reset
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_byte = 1'b0;
    req_addr = 15'h0010;
    req_wdata = 16'hCAFE;
    @(negedge clk);
    check("mid_accept", 32'(if_be.req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_byte = 1'b1;
    req_addr = 15'h0020;
    req_wdata = 16'h0077;
    @(negedge clk);
    check("mid_wr_masked", 32'(if_be.mem_wr), 32'd0);
    check("mid_en_masked", 32'(if_be.mem_en), 32'd0);
    check("mid_rsp",       32'(if_be.rsp_valid), 32'd0);
    check("mid_ready",     32'(if_be.req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_ready", 32'(if_be.req_ready), 32'd0);
    check("mid_rst_rsp",   32'(if_be.rsp_valid), 32'd0);
    check("mid_rst_rdata", 32'(if_be.rsp_rdata), 32'd0);
    check("mid_rst_en",    32'(if_be.mem_en), 32'd0);
    check("mid_rst_en_le", 32'(if_le.mem_en), 32'd0);
    check("mid_rst_wr",    32'(if_be.mem_wr), 32'd0);
    check("mid_rst_addr",  32'(if_be.mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(if_be.mem_wdata), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("after_rst_en",    32'(if_be.mem_en), 32'd0);
    check("after_rst_rsp",   32'(if_be.rsp_valid), 32'd0);
    check("after_rst_ready", 32'(if_be.req_ready), 32'd1);
    check("ram_be_10", 32'(ram_be[15'h0010]), 32'hCA);
    check("ram_be_11", 32'(ram_be[15'h0011]), 32'h5A);
    check("ram_le_10", 32'(ram_le[15'h0010]), 32'hFE);
    check("ram_le_11", 32'(ram_le[15'h0011]), 32'h5A);
    check("ram_be_20", 32'(ram_be[15'h0020]), 32'h00);
    @(posedge clk);
    #1;

    // One-cycle reset, then a request on the very first cycle after it
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    txn("r11", 1'b0, 1'b1, 15'h0011, 16'h0000, rb, rl);
    check("r11_be", 32'(rb), 32'h005A);
    txn("r10", 1'b0, 1'b1, 15'h0010, 16'h0000, rb, rl);
    check("r10_be", 32'(rb), 32'h00CA);
    check("r10_le", 32'(rl), 32'h00FE);
    txn("r20", 1'b0, 1'b1, 15'h0020, 16'h0000, rb, rl);
    check("r20_be", 32'(rb), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
